// File: rtl/alu32_pipe.sv
// rtl/alu32_pipe.sv - two-stage pipelined 32-bit add/subtract unit with flags, sticky flags and delivery counter
module alu32_pipe #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub_add,
    input  logic [31:0]      a,
    input  logic [31:0]      b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      result,
    output logic             carry,
    output logic             zero,
    output logic             overflow,
    input  logic             clr_sticky,
    output logic             sticky_ovf,
    output logic             sticky_carry,
    output logic [CNT_W-1:0] op_count
);

    // Stage 1 operand registers
    logic        s1Valid;
    logic        s1SubAdd;
    logic [31:0] s1A;
    logic [31:0] s1B;

    // Stage 2 valid; the result/flag registers are the output ports themselves
    logic        s2Valid;

    logic        acceptIn;
    logic        advance;
    logic        deliver;
    logic [31:0] bx;
    logic [32:0] sum;
    logic        ovfNext;

    assign out_valid = s2Valid;

    // Ready depends only on pipeline state and out_ready, never on in_valid
    always_comb begin
        in_ready = !s1Valid || !s2Valid || out_ready;
        acceptIn = in_valid && in_ready;
        advance  = s1Valid && (!s2Valid || out_ready);
        deliver  = s2Valid && out_ready;
    end

    // Subtract is a + ~b + 1, so carry-out is NOT-borrow
    always_comb begin
        bx      = s1B ^ {32{s1SubAdd}};
        sum     = {1'b0, s1A} + {1'b0, bx} + {32'd0, s1SubAdd};
        ovfNext = (s1A[31] == bx[31]) && (sum[31] != s1A[31]);
    end

    // Stage 1: capture operands on handshake, empty when drained into stage 2
    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid  <= 1'b0;
            s1SubAdd <= 1'b0;
            s1A      <= 32'd0;
            s1B      <= 32'd0;
        end else if (acceptIn) begin
            s1Valid  <= 1'b1;
            s1SubAdd <= sub_add;
            s1A      <= a;
            s1B      <= b;
        end else if (advance) begin
            s1Valid  <= 1'b0;
        end
    end

    // Stage 2: load computed result on advance; hold steady while stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            s2Valid  <= 1'b0;
            result   <= 32'd0;
            carry    <= 1'b0;
            zero     <= 1'b0;
            overflow <= 1'b0;
        end else if (advance) begin
            s2Valid  <= 1'b1;
            result   <= sum[31:0];
            carry    <= sum[32];
            zero     <= (sum[31:0] == 32'd0);
            overflow <= ovfNext;
        end else if (deliver) begin
            s2Valid  <= 1'b0;
        end
    end

    // Delivery bookkeeping: sticky flags (set beats clear) and wrapping counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_ovf   <= 1'b0;
            sticky_carry <= 1'b0;
            op_count     <= '0;
        end else begin
            sticky_ovf   <= (sticky_ovf && !clr_sticky) || (deliver && overflow);
            sticky_carry <= (sticky_carry && !clr_sticky) || (deliver && carry);
            if (deliver) begin
                op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
